// File: rtl/jesd_pkg.sv
// Shared JESD receive-path definitions: character width, K28.5 comma
// patterns for both running disparities, and the word aligner state encoding.
package jesd_pkg;

  localparam int CHAR_W = 10;

  // K28.5 as abcdei fghj with a in bit 9 (first on the line)
  localparam logic [CHAR_W-1:0] K28_5_RDN = 10'h0FA;
  localparam logic [CHAR_W-1:0] K28_5_RDP = 10'h305;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  // 4-bit increment that sticks at 15
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/comma_detect.sv
// Combinational K28.5 detector: flags a 10-bit character equal to either
// running-disparity form of the comma. Shared with the ILAS checker.
module comma_detect
  import jesd_pkg::*;
#(
  parameter logic [CHAR_W-1:0] COMMA_RDN = K28_5_RDN,
  parameter logic [CHAR_W-1:0] COMMA_RDP = K28_5_RDP
) (
  input  logic [CHAR_W-1:0] char_in,
  output logic              comma_hit
);

  logic [CHAR_W-1:0] match_rdn;
  logic [CHAR_W-1:0] match_rdp;

  // Per-bit equality against each disparity, then AND-reduce
  for (genvar gi = 0; gi < CHAR_W; gi++) begin : g_bit
    assign match_rdn[gi] = (char_in[gi] == COMMA_RDN[gi]);
    assign match_rdp[gi] = (char_in[gi] == COMMA_RDP[gi]);
  end

  assign comma_hit = (&match_rdn) | (&match_rdp);

endmodule

// File: rtl/deserializer_aligner.sv
// Serial-to-10-bit deserializer with K28.5 comma alignment.
// Bits shift in MSB first; the aligner hunts for a comma, verifies that
// LOCK_COUNT commas land on the same 10-bit boundary, then presents one
// aligned character per 10 bit clocks with a single-cycle valid strobe.
// UNLOCK_COUNT off-boundary commas while locked drop back to hunting.
// Optional: define DESER_RELOCK_CNT_EN to add relock_cnt, a saturating
// count of LOCKED -> HUNT transitions.
module deserializer_aligner
  import jesd_pkg::*;
#(
  parameter logic [CHAR_W-1:0] COMMA_RDN    = K28_5_RDN,
  parameter logic [CHAR_W-1:0] COMMA_RDP    = K28_5_RDP,
  parameter int unsigned       LOCK_COUNT   = 3,
  parameter int unsigned       UNLOCK_COUNT = 4
) (
  input  logic              bit_clk,
  input  logic              rst_n,
  input  logic              in_data,
  output logic [CHAR_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_is_comma,
`ifdef DESER_RELOCK_CNT_EN
  output logic [7:0]        relock_cnt,
`endif
  output logic              locked
);

  localparam logic [1:0] S_HUNT   = HUNT;
  localparam logic [1:0] S_VERIFY = VERIFY;
  localparam logic [1:0] S_LOCKED = LOCKED;

  localparam logic [3:0] LOCK_CNT4   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_CNT4 = 4'(UNLOCK_COUNT);

  logic [CHAR_W-1:0] sr_reg;
  logic [3:0]        phase_cnt_reg, phase_cnt_next;
  logic [1:0]        state_reg, state_next;
  logic [3:0]        good_cnt_reg, good_cnt_next;
  logic [3:0]        bad_cnt_reg, bad_cnt_next;
  logic              comma_hit;
  logic              boundary;
  logic              realign;
  logic              emit;

  logic [CHAR_W-1:0] out_data_reg;
  logic              out_valid_reg;
  logic              out_is_comma_reg;
  logic              locked_reg;

  comma_detect #(
    .COMMA_RDN (COMMA_RDN),
    .COMMA_RDP (COMMA_RDP)
  ) u_comma_detect (
    .char_in   (sr_reg),
    .comma_hit (comma_hit)
  );

  assign boundary = (phase_cnt_reg == 4'd0);

  // Next-state logic for the hunt / verify / locked alignment FSM
  always_comb begin
    state_next     = state_reg;
    good_cnt_next  = good_cnt_reg;
    bad_cnt_next   = bad_cnt_reg;
    realign        = 1'b0;
    emit           = 1'b0;
    phase_cnt_next = (phase_cnt_reg == 4'd9) ? 4'd0 : phase_cnt_reg + 4'd1;

    case (state_reg)
      S_HUNT: begin
        if (comma_hit) begin
          realign       = 1'b1;
          good_cnt_next = 4'd1;
          if (LOCK_COUNT == 1) begin
            state_next   = S_LOCKED;
            bad_cnt_next = 4'd0;
          end else begin
            state_next = S_VERIFY;
          end
        end
      end
      S_VERIFY: begin
        if (boundary) begin
          if (comma_hit) begin
            good_cnt_next = sat_inc4(good_cnt_reg);
            if (good_cnt_next >= LOCK_CNT4) begin
              state_next   = S_LOCKED;
              bad_cnt_next = 4'd0;
            end
          end else begin
            state_next = S_HUNT;
          end
        end else if (comma_hit) begin
          // A comma off the candidate boundary restarts verification on it
          realign       = 1'b1;
          good_cnt_next = 4'd1;
          state_next    = S_VERIFY;
        end
      end
      S_LOCKED: begin
        emit = boundary;
        if (comma_hit) begin
          if (boundary) begin
            bad_cnt_next = 4'd0;
          end else begin
            bad_cnt_next = sat_inc4(bad_cnt_reg);
            if (bad_cnt_next >= UNLOCK_CNT4) begin
              state_next = S_HUNT;
            end
          end
        end
      end
      default: state_next = S_HUNT;
    endcase

    if (realign) begin
      phase_cnt_next = 4'd1;
    end
  end

  // Shift register, phase counter and FSM state
  always_ff @(posedge bit_clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg        <= '0;
      phase_cnt_reg <= 4'd0;
      state_reg     <= S_HUNT;
      good_cnt_reg  <= 4'd0;
      bad_cnt_reg   <= 4'd0;
    end else begin
      sr_reg        <= {sr_reg[CHAR_W-2:0], in_data};
      phase_cnt_reg <= phase_cnt_next;
      state_reg     <= state_next;
      good_cnt_reg  <= good_cnt_next;
      bad_cnt_reg   <= bad_cnt_next;
    end
  end

  // Output register: capture the aligned character one cycle after a boundary
  always_ff @(posedge bit_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg     <= '0;
      out_valid_reg    <= 1'b0;
      out_is_comma_reg <= 1'b0;
      locked_reg       <= 1'b0;
    end else begin
      out_valid_reg <= emit;
      locked_reg    <= (state_next == S_LOCKED);
      if (emit) begin
        out_data_reg     <= sr_reg;
        out_is_comma_reg <= comma_hit;
      end
    end
  end

  assign out_data     = out_data_reg;
  assign out_valid    = out_valid_reg;
  assign out_is_comma = out_is_comma_reg;
  assign locked       = locked_reg;

`ifdef DESER_RELOCK_CNT_EN
  logic [7:0] relock_cnt_reg;

  // Count lock losses, sticking at 255
  always_ff @(posedge bit_clk or negedge rst_n) begin
    if (!rst_n) begin
      relock_cnt_reg <= 8'h00;
    end else if ((state_reg == S_LOCKED) && (state_next == S_HUNT) &&
                 (relock_cnt_reg != 8'hFF)) begin
      relock_cnt_reg <= relock_cnt_reg + 8'h01;
    end
  end

  assign relock_cnt = relock_cnt_reg;
`endif

endmodule
